coin_input_conditioner: RTL and testbench

- Front-end stage for the vending FSM.
- Synchronizes and debounces the raw board inputs at 100 MHz: insert button, cancel button, coin-value switches and drink-select switches.
- Turns each button press into a request that is held until the slow (1 Hz) FSM clock has certainly sampled it.
- Drives insert, coin_val, drink_op and cancel_flag of the FSM.

---
 rtl/coin_input_conditioner_if.sv | 24 ++
 rtl/coin_input_conditioner.sv | 154 +++++++++++++++
 tb/tb_coin_input_conditioner.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_input_conditioner_if.sv
// Board-side signal bundle of the coin input conditioner: raw inputs and slow clock in,
// conditioned requests to the vending FSM out.
interface coin_input_conditioner_if;
    logic       insert_raw;
    logic       cancel_raw;
    logic [1:0] coin_raw;
    logic [1:0] drink_raw;
    logic       clk_slow;
    logic       insert;
    logic [1:0] coin_val;
    logic       cancel_flag;
    logic [1:0] drink_op;
    logic       busy;

    modport master (
        output insert_raw, cancel_raw, coin_raw, drink_raw, clk_slow,
        input  insert, coin_val, cancel_flag, drink_op, busy
    );

    modport slave (
        input  insert_raw, cancel_raw, coin_raw, drink_raw, clk_slow,
        output insert, coin_val, cancel_flag, drink_op, busy
    );
endinterface

// File: rtl/coin_input_conditioner.sv
// Synchronizes and debounces the vending machine's raw buttons/switches and stretches each
// press into a request held until the 1 Hz FSM clock has certainly sampled it.
module coin_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int CNT_W           = 21,
    parameter int LOW_CONFIRM     = 4
) (
    input  logic                     clk100MHZ,
    input  logic                     rst_n,
    coin_input_conditioner_if.slave  bus
);

    localparam int              LC_W    = $clog2(LOW_CONFIRM + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LC_W-1:0]  LC_LAST = LC_W'(LOW_CONFIRM - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_LOW  = 2'd1;
    localparam logic [1:0] WAIT_RISE = 2'd2;
    localparam logic [1:0] RELEASE   = 2'd3;

    logic [6:0]       w_raw;
    logic [6:0]       r_meta;
    logic [6:0]       r_sync;
    logic [1:0]       w_chIn [4];
    logic [1:0]       r_deb  [4];
    logic [CNT_W-1:0] r_cnt  [4];
    logic             r_insPrev;
    logic             r_canPrev;
    logic             r_slowPrev;
    logic             w_insEvent;
    logic             w_canEvent;
    logic             w_slowSync;
    logic             w_slowRise;
    logic [1:0]       r_state;
    logic [LC_W-1:0]  r_lowCnt;
    logic             r_insert;
    logic             r_cancel;
    logic             r_busy;
    logic [1:0]       r_coinVal;

    assign w_raw = {bus.clk_slow, bus.drink_raw, bus.coin_raw, bus.cancel_raw, bus.insert_raw};

    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
        end
    end

    // Channels 0..3: insert, cancel, coin, drink; the buttons ride in bit 0 of a 2-bit slot.
    always_comb begin
        w_chIn[0] = {1'b0, r_sync[0]};
        w_chIn[1] = {1'b0, r_sync[1]};
        w_chIn[2] = r_sync[3:2];
        w_chIn[3] = r_sync[5:4];
    end

    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_deb[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_chIn[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_deb[i] <= w_chIn[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_slowSync = r_sync[6];
    assign w_slowRise = w_slowSync & ~r_slowPrev;
    assign w_insEvent = r_deb[0][0] & ~r_insPrev;
    assign w_canEvent = r_deb[1][0] & ~r_canPrev;

    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_insPrev  <= 1'b0;
            r_canPrev  <= 1'b0;
            r_slowPrev <= 1'b0;
        end else begin
            r_insPrev  <= r_deb[0][0];
            r_canPrev  <= r_deb[1][0];
            r_slowPrev <= w_slowSync;
        end
    end

    // Outputs drop on entry to RELEASE, so busy is already low there and a press is taken as in IDLE.
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_lowCnt  <= '0;
            r_insert  <= 1'b0;
            r_cancel  <= 1'b0;
            r_busy    <= 1'b0;
            r_coinVal <= '0;
        end else begin
            case (r_state)
                IDLE, RELEASE: begin
                    r_lowCnt <= '0;
                    if (w_canEvent) begin
                        r_cancel <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= WAIT_LOW;
                    end else if (w_insEvent) begin
                        r_insert  <= 1'b1;
                        r_coinVal <= r_deb[2];
                        r_busy    <= 1'b1;
                        r_state   <= WAIT_LOW;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WAIT_LOW: begin
                    if (w_slowSync) begin
                        r_lowCnt <= '0;
                    end else if (r_lowCnt == LC_LAST) begin
                        r_lowCnt <= '0;
                        r_state  <= WAIT_RISE;
                    end else begin
                        r_lowCnt <= r_lowCnt + 1'b1;
                    end
                end
                WAIT_RISE: begin
                    if (w_slowRise) begin
                        r_insert <= 1'b0;
                        r_cancel <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= RELEASE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.insert      = r_insert;
    assign bus.cancel_flag = r_cancel;
    assign bus.busy        = r_busy;
    assign bus.coin_val    = r_coinVal;
    assign bus.drink_op    = r_deb[3];

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Randomized and directed bench for coin_input_conditioner; a history-based reference model
// predicts every output on every cycle.
module tb_coin_input_conditioner;

    localparam int DEB      = 8;
    localparam int LOWC     = 4;
    localparam int SLOW_PER = 64;
    localparam int MAXE     = 16384;

    logic clk;
    logic rst_n;

    coin_input_conditioner_if bus ();

    coin_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(4),
        .LOW_CONFIRM(LOWC)
    ) dut (
        .clk100MHZ(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checkCount = 0;
    int         errorCount = 0;
    logic [1:0] hist [5][MAXE];
    int         edgeNo     = 0;
    int         resetEdge  = 0;
    int         raiseEdge  = 0;
    bit         inReset    = 1'b1;
    logic [1:0] deb [4];
    int         lastChg [4];
    bit         evIns, evCan, expInsert, expCancel, expBusy;
    logic [1:0] expCoin, expDrink;
    int         slowPhase  = 0;
    bit         slowRun    = 1'b1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
        checkCount++;
        if (obs !== expVal) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, expVal, $time);
        end
    endtask

    // Synchronized value seen after edge k is the raw value sampled one edge earlier, zero across reset.
    function automatic logic [1:0] syncAt(input int ch, input int k);
        if (k >= 1 && k - 1 >= resetEdge) return hist[ch][k-1];
        return 2'b00;
    endfunction

    function automatic bit debAccepts(input int ch, input int n);
        if (n - DEB < lastChg[ch]) return 1'b0;
        for (int i = 1; i <= DEB; i++)
            if (syncAt(ch, n - i) == deb[ch]) return 1'b0;
        return 1'b1;
    endfunction

    // Release at the first synchronized rise preceded by LOWC lows that all came after the raise.
    function automatic bit slowReleaseAt(input int j);
        if (j - LOWC < raiseEdge) return 1'b0;
        if (syncAt(4, j) != 2'b01) return 1'b0;
        for (int i = 1; i <= LOWC; i++)
            if (syncAt(4, j - i) != 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < 4; c++) deb[c] = 2'b00;
        evIns = 1'b0; evCan = 1'b0;
        expInsert = 1'b0; expCancel = 1'b0; expBusy = 1'b0;
        expCoin = 2'b00; expDrink = 2'b00;
        inReset = 1'b1;
    endtask

    task automatic modelStep();
        int n;
        logic [1:0] oldIns, oldCan;
        edgeNo++;
        n = edgeNo;
        if (n >= MAXE) begin
            $display("[TB] FAIL edgeBudget: got %0d edges, limit %0d", n, MAXE);
            $fatal(1, "[TB] model history exhausted");
        end
        hist[0][n] = {1'b0, bus.insert_raw};
        hist[1][n] = {1'b0, bus.cancel_raw};
        hist[2][n] = bus.coin_raw;
        hist[3][n] = bus.drink_raw;
        hist[4][n] = {1'b0, bus.clk_slow};
        if (!rst_n) return;
        if (inReset) begin
            resetEdge = n;
            for (int c = 0; c < 4; c++) lastChg[c] = n;
            inReset = 1'b0;
        end
        if (!expBusy) begin
            if (evCan) begin
                expCancel = 1'b1; expBusy = 1'b1; raiseEdge = n;
            end else if (evIns) begin
                expInsert = 1'b1; expCoin = deb[2]; expBusy = 1'b1; raiseEdge = n;
            end
        end else if (slowReleaseAt(n - 1)) begin
            expInsert = 1'b0; expCancel = 1'b0; expBusy = 1'b0;
        end
        oldIns = deb[0];
        oldCan = deb[1];
        for (int c = 0; c < 4; c++) begin
            if (debAccepts(c, n)) begin
                deb[c]     = syncAt(c, n - 1);
                lastChg[c] = n;
            end
        end
        evIns    = deb[0][0] && !oldIns[0];
        evCan    = deb[1][0] && !oldCan[0];
        expDrink = deb[3];
    endtask

    task automatic compareAll();
        checkOutput("insert",      32'(bus.insert),      32'(expInsert));
        checkOutput("cancel_flag", 32'(bus.cancel_flag), 32'(expCancel));
        checkOutput("busy",        32'(bus.busy),        32'(expBusy));
        checkOutput("coin_val",    32'(bus.coin_val),    32'(expCoin));
        checkOutput("drink_op",    32'(bus.drink_op),    32'(expDrink));
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
            compareAll();
            if (slowRun) begin
                slowPhase    = (slowPhase + 1) % SLOW_PER;
                bus.clk_slow = (slowPhase >= SLOW_PER / 2);
            end
        end
    endtask

    task automatic applyStimulus(input logic ins, input logic can, input logic [1:0] coin, input logic [1:0] drink);
        bus.insert_raw = ins;
        bus.cancel_raw = can;
        bus.coin_raw   = coin;
        bus.drink_raw  = drink;
    endtask

    function automatic logic sigOf(input int sel);
        case (sel)
            0:       return bus.insert;
            1:       return bus.cancel_flag;
            default: return bus.busy;
        endcase
    endfunction

    task automatic waitFor(input int sel, input logic val, input int limit, output int cycles);
        cycles = 0;
        while (cycles < limit && sigOf(sel) !== val) begin
            runCycles(1);
            cycles++;
        end
    endtask

    task automatic waitIdle(input string tag);
        int cyc;
        waitFor(2, 1'b0, 200, cyc);
        checkOutput(tag, 32'(bus.busy), 32'd0);
    endtask

    // Leaves the press landing so the request rises one cycle after a synchronized slow rise.
    task automatic alignToSlow();
        int guard = 0;
        while (slowPhase != 24 && guard < 2 * SLOW_PER) begin
            runCycles(1);
            guard++;
        end
    endtask

    initial begin
        int cyc;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00);
        bus.clk_slow = 1'b0;
        modelReset();
        #1 rst_n = 1'b0;
        #1 compareAll();
        runCycles(3);
        rst_n = 1'b1;
        runCycles(10);

        applyStimulus(1'b0, 1'b0, 2'b10, 2'b01);
        runCycles(15);
        checkOutput("drinkLevel", 32'(bus.drink_op), 32'd1);
        applyStimulus(1'b1, 1'b0, 2'b10, 2'b01);
        waitFor(0, 1'b1, 40, cyc);
        checkOutput("insertLatency", cyc, 11);
        checkOutput("insertCoin", 32'(bus.coin_val), 32'd2);
        checkOutput("busyWithInsert", 32'(bus.busy), 32'd1);
        runCycles(9);
        applyStimulus(1'b0, 1'b0, 2'b10, 2'b01);
        waitFor(0, 1'b0, 120, cyc);
        checkOutput("insertReleased", 32'(bus.insert), 32'd0);
        checkOutput("busyReleased", 32'(bus.busy), 32'd0);
        runCycles(15);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(i % 2 == 0, 1'b0, 2'b10, 2'b01);
            runCycles(3);
        end
        checkOutput("noBounceEvent", 32'(bus.busy), 32'd0);
        applyStimulus(1'b1, 1'b0, 2'b10, 2'b01);
        waitFor(0, 1'b1, 40, cyc);
        checkOutput("bounceLatency", cyc, 11);
        runCycles(5);
        applyStimulus(1'b0, 1'b0, 2'b10, 2'b01);
        waitIdle("bounceReleased");
        runCycles(15);

        applyStimulus(1'b1, 1'b1, 2'b10, 2'b01);
        waitFor(1, 1'b1, 40, cyc);
        checkOutput("cancelLatency", cyc, 11);
        checkOutput("cancelBeatsInsert", 32'(bus.insert), 32'd0);
        checkOutput("cancelKeepsCoin", 32'(bus.coin_val), 32'd2);
        runCycles(5);
        applyStimulus(1'b0, 1'b0, 2'b10, 2'b01);
        waitIdle("cancelReleased");
        runCycles(15);

        alignToSlow();
        applyStimulus(1'b1, 1'b0, 2'b10, 2'b01);
        waitFor(0, 1'b1, 40, cyc);
        checkOutput("alignedLatency", cyc, 11);
        applyStimulus(1'b0, 1'b0, 2'b10, 2'b01);
        waitFor(0, 1'b0, 150, cyc);
        checkOutput("holdToNextRise", cyc, 64);
        runCycles(15);

        alignToSlow();
        applyStimulus(1'b1, 1'b0, 2'b10, 2'b01);
        waitFor(0, 1'b1, 40, cyc);
        applyStimulus(1'b0, 1'b0, 2'b01, 2'b01);
        runCycles(12);
        applyStimulus(1'b1, 1'b0, 2'b01, 2'b01);
        runCycles(14);
        checkOutput("busyDropCoin", 32'(bus.coin_val), 32'd2);
        checkOutput("busyStillHeld", 32'(bus.insert), 32'd1);
        applyStimulus(1'b0, 1'b0, 2'b01, 2'b01);
        waitFor(2, 1'b0, 100, cyc);
        runCycles(20);
        checkOutput("droppedNotQueued", 32'(bus.busy), 32'd0);
        applyStimulus(1'b1, 1'b0, 2'b01, 2'b01);
        waitFor(0, 1'b1, 40, cyc);
        checkOutput("freshPressLatency", cyc, 11);
        checkOutput("freshCoin", 32'(bus.coin_val), 32'd1);
        runCycles(5);
        applyStimulus(1'b0, 1'b0, 2'b01, 2'b01);
        waitIdle("freshReleased");
        runCycles(15);

        alignToSlow();
        applyStimulus(1'b1, 1'b0, 2'b01, 2'b10);
        waitFor(0, 1'b1, 40, cyc);
        applyStimulus(1'b0, 1'b0, 2'b01, 2'b10);
        runCycles(40);
        checkOutput("waitRiseBusy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("resetInsert", 32'(bus.insert), 32'd0);
        checkOutput("resetBusy", 32'(bus.busy), 32'd0);
        checkOutput("resetCoin", 32'(bus.coin_val), 32'd0);
        checkOutput("resetDrink", 32'(bus.drink_op), 32'd0);
        runCycles(3);
        rst_n = 1'b1;
        runCycles(150);
        checkOutput("noReappear", 32'(bus.busy), 32'd0);

        alignToSlow();
        slowRun = 1'b0;
        applyStimulus(1'b1, 1'b0, 2'b11, 2'b10);
        waitFor(0, 1'b1, 60, cyc);
        applyStimulus(1'b0, 1'b0, 2'b11, 2'b10);
        runCycles(200);
        checkOutput("stuckSlowBusy", 32'(bus.busy), 32'd1);
        slowRun = 1'b1;
        waitIdle("stuckResumed");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(23) == 0) bus.insert_raw = ~bus.insert_raw;
            if ($urandom_range(23) == 0) bus.cancel_raw = ~bus.cancel_raw;
            if ($urandom_range(39) == 0) bus.coin_raw   = 2'($urandom);
            if ($urandom_range(39) == 0) bus.drink_raw  = 2'($urandom);
            runCycles(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
